piso_frame_serializer: RTL and testbench
========================================

Name: piso_frame_serializer

Overview:
- Parallel-in, serial-out stage directly upstream of siso_shift_reg; drives its serial_in.
- Accepts a DATA_W-bit word over a valid/ready handshake and emits it one bit per clock_in cycle.
- Supports gapless back-to-back frames and an idle line level between frames.
- Provides frame status strobes to the surrounding control logic.

Parameters:
- DATA_W, 8, word width in bits; must be >= 2.
- MSB_FIRST, 1, 1 = transmit bit DATA_W-1 first; 0 = transmit bit 0 first.
- IDLE_LVL, 1'b0, serial_out level when no frame is active.

Ports:
- clock_in  input  1  single clock, all state updates on rising edge.
- resetn  input  1  asynchronous, active-low reset.
- par_in  input  DATA_W  word to serialize; sampled only on an accepting edge.
- load_valid  input  1  producer has a word on par_in.
- load_ready  output  1  block can accept a word this cycle.
- serial_out  output  1  serial data to the downstream shift register.
- bit_valid  output  1  serial_out carries a frame bit this cycle.
- frame_busy  output  1  a frame is in progress.
- frame_done  output  1  one-cycle strobe during the final bit of a frame.

Behaviour:
- Reset (async, resetn=0) forces the following immediately, independent of clock_in:
  - state = IDLE, shift register = 0, bit counter = 0.
  - serial_out = IDLE_LVL; bit_valid, frame_busy and frame_done = 0.
  - load_ready = 0 while resetn=0; 1 from the first cycle after release.
- FSM states: IDLE, SHIFT, PAR (PAR exists only with the optional feature).
- Accept: a rising edge with load_valid=1 and load_ready=1.
  - par_in is captured and the bit counter cleared.
  - state moves to SHIFT.
- Latency: the first bit appears on serial_out in the cycle immediately after the accepting edge.
- Each bit is held for exactly one clock_in cycle; a frame occupies DATA_W cycles.
- Ordering follows MSB_FIRST. The shift register shifts toward the output end each edge in SHIFT.
- All outputs are registered-state driven only; there is no combinational path from par_in or load_valid to any output.
- load_ready is high:
  - in IDLE;
  - in the final bit cycle of a frame (bit counter = DATA_W-1 in SHIFT, or in PAR when built).
  - It is low in all other SHIFT cycles.
- load_valid while load_ready=0 is ignored; par_in changes mid-frame have no effect.
- Last-bit cycle:
  - frame_done = 1 for exactly that cycle.
  - If a word is accepted, the next cycle carries its first bit: no gap; frame_busy and bit_valid stay high.
  - If nothing is accepted, the next state is IDLE and serial_out returns to IDLE_LVL.
- frame_busy = bit_valid = (state != IDLE).
- Bit counter width is clog2(DATA_W). It wraps only by explicit clear on accept, never by overflow.
- Reset mid-frame aborts the frame; the partial word is discarded and no frame_done is issued.

Optional Feature:
- Macro: SERIALIZER_PARITY_EN.
- Defined:
  - After the DATA_W data bits, state PAR emits one even-parity bit (XOR of the captured word) with bit_valid=1.
  - Frame length becomes DATA_W+1 cycles.
  - load_ready and frame_done move from the last data bit to the PAR cycle.
- Undefined:
  - The PAR state, parity register and parity logic are absent.
  - Frame length is DATA_W cycles.

Decomposition:
- Package serializer_pkg:
  - FSM state encoding constants ST_IDLE, ST_SHIFT, ST_PAR.
  - clog2 width function for the bit counter.
- Natural sub-module: serializer_parity_calc.
  - Combinational XOR reduction of the captured word.
  - Instantiated only under SERIALIZER_PARITY_EN.

Test Plan:
- Reset then load 8'hB8, MSB_FIRST=1 -> serial_out 1,0,1,1,1,0,0,0 on cycles 1-8 after accept; frame_done only on cycle 8; serial_out=0, frame_busy=0 on cycle 9.
- Back-to-back: 8'hB8 then 8'h5A, load_valid held high -> 16 contiguous bits 10111000 01011010; bit_valid never drops; frame_done on cycles 8 and 16.
- Load attempt mid-frame: load_valid=1 with 8'hFF during cycles 2-6 of an 8'hB8 frame -> load_ready=0, output stream unchanged, 8'hFF not transmitted.
- Reset mid-frame: assert resetn=0 between clock edges after 3 bits of 8'hB8 -> serial_out=IDLE_LVL and frame_busy=0 immediately; no frame_done. After release, 8'h01 transmits cleanly as 00000001.
- MSB_FIRST=0 build, load 8'hB8 -> serial_out 0,0,0,1,1,1,0,1.
- SERIALIZER_PARITY_EN defined:
  - 8'hB8 -> 9th bit 0.
  - 8'h07 -> 9th bit 1.
  - frame_done and load_ready on the 9th cycle only.

Source files
------------

// File: rtl/serializer_pkg.sv
// Shared types and helpers for the parallel-in/serial-out frame serializer.
// ST_PAR is only reachable when SERIALIZER_PARITY_EN is defined.
package serializer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAR   = 2'd2
    } state_t;

    // Smallest width able to index 0 .. v-1 (at least 1 bit).
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        if (r == 0) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/serializer_parity_calc.sv
// Even-parity bit of a word: the XOR of all its bits.
// Instantiated by piso_frame_serializer only when SERIALIZER_PARITY_EN is defined.
module serializer_parity_calc #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] word,
    output logic              parity
);

    assign parity = ^word;

endmodule

// File: rtl/piso_frame_serializer.sv
// Parallel-in/serial-out frame serializer with valid/ready load and gapless frames.
// Define SERIALIZER_PARITY_EN to append an even-parity bit after the data bits.
module piso_frame_serializer
    import serializer_pkg::*;
#(
    parameter int   DATA_W    = 8,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_LVL  = 1'b0
) (
    input  logic              clock_in,
    input  logic              resetn,
    input  logic [DATA_W-1:0] par_in,
    input  logic              load_valid,
    output logic              load_ready,
    output logic              serial_out,
    output logic              bit_valid,
    output logic              frame_busy,
    output logic              frame_done
);

    localparam int              CNT_W    = clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    state_t            state;
    logic [DATA_W-1:0] shreg;
    logic [CNT_W-1:0]  bit_cnt;
    logic              armed;
    logic              last_data;
    logic              frame_end;
    logic              accept;
    logic              head_bit;

    assign last_data = (state == ST_SHIFT) && (bit_cnt == CNT_LAST);
    assign head_bit  = MSB_FIRST ? shreg[DATA_W-1] : shreg[0];

`ifdef SERIALIZER_PARITY_EN
    logic par_q;
    logic par_next;

    serializer_parity_calc #(
        .DATA_W (DATA_W)
    ) u_parity (
        .word   (par_in),
        .parity (par_next)
    );

    assign frame_end = (state == ST_PAR);
`else
    assign frame_end = last_data;
`endif

    // armed keeps load_ready low until the first edge after reset release.
    assign load_ready = armed && ((state == ST_IDLE) || frame_end);
    assign accept     = load_valid && load_ready;
    assign bit_valid  = (state != ST_IDLE);
    assign frame_busy = (state != ST_IDLE);
    assign frame_done = frame_end;

    always_comb begin
        serial_out = IDLE_LVL;
        case (state)
            ST_SHIFT: serial_out = head_bit;
`ifdef SERIALIZER_PARITY_EN
            ST_PAR:   serial_out = par_q;
`endif
            default:  serial_out = IDLE_LVL;
        endcase
    end

    always_ff @(posedge clock_in or negedge resetn) begin
        if (!resetn) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            armed   <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            armed <= 1'b1;
            if (accept) begin
                // A load in the last-bit cycle chains straight into the next frame.
                shreg   <= par_in;
                bit_cnt <= '0;
                state   <= ST_SHIFT;
`ifdef SERIALIZER_PARITY_EN
                par_q   <= par_next;
`endif
            end else begin
                case (state)
                    ST_SHIFT: begin
                        if (MSB_FIRST)
                            shreg <= {shreg[DATA_W-2:0], 1'b0};
                        else
                            shreg <= {1'b0, shreg[DATA_W-1:1]};
                        if (last_data) begin
`ifdef SERIALIZER_PARITY_EN
                            state <= ST_PAR;
`else
                            state <= ST_IDLE;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
`ifdef SERIALIZER_PARITY_EN
                    ST_PAR:  state <= ST_IDLE;
`endif
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_piso_frame_serializer.sv
// Testbench for piso_frame_serializer: MSB-first and LSB-first instances share stimulus;
// directed table, mid-frame reset sequence and random traffic against a queue model.
module tb_piso_frame_serializer;

    localparam int   N    = 8;
    localparam logic IDLE = 1'b0;
`ifdef SERIALIZER_PARITY_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         resetn = 1'b1;
    logic [N-1:0] par_in = '0;
    logic         load_valid = 1'b0;

    logic m_ready, m_so, m_bv, m_busy, m_done;
    logic l_ready, l_so, l_bv, l_busy, l_done;

    piso_frame_serializer #(.DATA_W(N), .MSB_FIRST(1'b1), .IDLE_LVL(IDLE)) u_msb (
        .clock_in   (clk),
        .resetn     (resetn),
        .par_in     (par_in),
        .load_valid (load_valid),
        .load_ready (m_ready),
        .serial_out (m_so),
        .bit_valid  (m_bv),
        .frame_busy (m_busy),
        .frame_done (m_done)
    );

    piso_frame_serializer #(.DATA_W(N), .MSB_FIRST(1'b0), .IDLE_LVL(IDLE)) u_lsb (
        .clock_in   (clk),
        .resetn     (resetn),
        .par_in     (par_in),
        .load_valid (load_valid),
        .load_ready (l_ready),
        .serial_out (l_so),
        .bit_valid  (l_bv),
        .frame_busy (l_busy),
        .frame_done (l_done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int idx, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] actual=%b required=%b", name, idx, act, exp);
        end
    endtask

    // ---------------- reference model: queue of bits still to appear on the line
    typedef struct {
        logic m;
        logic l;
        logic last;
    } exp_t;

    exp_t q[$];
    bit   armed = 1'b0;

    task automatic push_frame(input logic [N-1:0] w);
        exp_t e;
        logic p;
        p = 1'b0;
        for (int i = 0; i < N; i++) p = p ^ w[i];
        for (int i = 0; i < N; i++) begin
            e.m    = w[N-1-i];
            e.l    = w[i];
            e.last = (i == N - 1) && !PEN;
            q.push_back(e);
        end
        if (PEN) begin
            e.m    = p;
            e.l    = p;
            e.last = 1'b1;
            q.push_back(e);
        end
    endtask

    function automatic logic model_ready();
        return armed && (q.size() == 0 || q[0].last);
    endfunction

    task automatic check_model(input int idx);
        logic bv, em, el, dn, rdy;
        bv  = (q.size() != 0);
        em  = bv ? q[0].m : IDLE;
        el  = bv ? q[0].l : IDLE;
        dn  = bv && q[0].last;
        rdy = model_ready();
        chk("so_msb",     idx, m_so,    em);
        chk("so_lsb",     idx, l_so,    el);
        chk("bit_valid",  idx, m_bv,    bv);
        chk("frame_busy", idx, m_busy,  bv);
        chk("frame_done", idx, m_done,  dn);
        chk("load_ready", idx, m_ready, rdy);
        chk("lsb_done",   idx, l_done,  dn);
    endtask

    // Drive inputs for one cycle (called at a negedge), advance model, return at next negedge.
    task automatic step(input logic lv, input logic [N-1:0] d);
        logic acc;
        load_valid = lv;
        par_in     = d;
        acc        = lv && model_ready();
        @(posedge clk);
        if (q.size() > 0) void'(q.pop_front());
        if (acc) push_frame(d);
        if (resetn) armed = 1'b1;
        @(negedge clk);
    endtask

    task automatic async_reset_now(input int idx);
        resetn = 1'b0;
        q.delete();
        armed = 1'b0;
        #1;
        chk("rst_so",    idx, m_so,    IDLE);
        chk("rst_busy",  idx, m_busy,  1'b0);
        chk("rst_bv",    idx, m_bv,    1'b0);
        chk("rst_done",  idx, m_done,  1'b0);
        chk("rst_ready", idx, m_ready, 1'b0);
    endtask

    // ---------------- directed table
    typedef struct {
        logic         lv;
        logic [N-1:0] d;
        logic         so;
        logic         sol;
        logic         bv;
        logic         dn;
        logic         rdy;
    } row_t;

    row_t tbl[$];

    task automatic add(input logic lv, input logic [N-1:0] d, input logic so, input logic sol,
                       input logic bv, input logic dn, input logic rdy);
        row_t r;
        r.lv = lv; r.d = d; r.so = so; r.sol = sol; r.bv = bv; r.dn = dn; r.rdy = rdy;
        tbl.push_back(r);
    endtask

    task automatic build_table();
        // 8'hB8 with ignored 8'hFF load attempts mid-frame
        add(1, 8'hB8, 1, 0, 1, 0, 0);
        add(1, 8'hFF, 0, 0, 1, 0, 0);
        add(1, 8'hFF, 1, 0, 1, 0, 0);
        add(1, 8'hFF, 1, 1, 1, 0, 0);
        add(1, 8'hFF, 1, 1, 1, 0, 0);
        add(1, 8'hFF, 0, 1, 1, 0, 0);
        add(0, 8'h00, 0, 0, 1, 0, 0);
`ifdef SERIALIZER_PARITY_EN
        add(0, 8'h00, 0, 1, 1, 0, 0);
        add(0, 8'h00, 0, 0, 1, 1, 1);
        add(0, 8'h00, 0, 0, 0, 0, 1);
        // 8'h07: parity bit 1
        add(1, 8'h07, 0, 1, 1, 0, 0);
        add(0, 8'h00, 0, 1, 1, 0, 0);
        add(0, 8'h00, 0, 1, 1, 0, 0);
        add(0, 8'h00, 0, 0, 1, 0, 0);
        add(0, 8'h00, 0, 0, 1, 0, 0);
        add(0, 8'h00, 1, 0, 1, 0, 0);
        add(0, 8'h00, 1, 0, 1, 0, 0);
        add(0, 8'h00, 1, 0, 1, 0, 0);
        add(0, 8'h00, 1, 1, 1, 1, 1);
        add(0, 8'h00, 0, 0, 0, 0, 1);
`else
        add(0, 8'h00, 0, 1, 1, 1, 1);
        add(0, 8'h00, 0, 0, 0, 0, 1);
        // back-to-back 8'hB8 then 8'h5A, load_valid high across the boundary
        add(1, 8'hB8, 1, 0, 1, 0, 0);
        add(1, 8'h5A, 0, 0, 1, 0, 0);
        add(1, 8'h5A, 1, 0, 1, 0, 0);
        add(1, 8'h5A, 1, 1, 1, 0, 0);
        add(1, 8'h5A, 1, 1, 1, 0, 0);
        add(1, 8'h5A, 0, 1, 1, 0, 0);
        add(1, 8'h5A, 0, 0, 1, 0, 0);
        add(1, 8'h5A, 0, 1, 1, 1, 1);
        add(1, 8'h5A, 0, 0, 1, 0, 0);
        add(0, 8'h00, 1, 1, 1, 0, 0);
        add(0, 8'h00, 0, 0, 1, 0, 0);
        add(0, 8'h00, 1, 1, 1, 0, 0);
        add(0, 8'h00, 1, 1, 1, 0, 0);
        add(0, 8'h00, 0, 0, 1, 0, 0);
        add(0, 8'h00, 1, 1, 1, 0, 0);
        add(0, 8'h00, 0, 0, 1, 1, 1);
        add(0, 8'h00, 0, 0, 0, 0, 1);
`endif
    endtask

    initial begin
        logic         lv;
        logic [N-1:0] d;

        // Reset state, asserted asynchronously before any clock edge
        #1;
        async_reset_now(0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_hold_ready", 0, m_ready, 1'b0);
        resetn = 1'b1;
        step(1'b0, '0);
        check_model(0);

        build_table();
        foreach (tbl[i]) begin
            step(tbl[i].lv, tbl[i].d);
            chk("tbl_so_msb", i, m_so,    tbl[i].so);
            chk("tbl_so_lsb", i, l_so,    tbl[i].sol);
            chk("tbl_bv",     i, m_bv,    tbl[i].bv);
            chk("tbl_busy",   i, m_busy,  tbl[i].bv);
            chk("tbl_done",   i, m_done,  tbl[i].dn);
            chk("tbl_ready",  i, m_ready, tbl[i].rdy);
        end

        // Reset after three bits of 8'hB8, then a clean 8'h01 frame
        step(1'b1, 8'hB8);
        check_model(100);
        step(1'b0, '0);
        check_model(101);
        step(1'b0, '0);
        check_model(102);
        chk("pre_rst_so", 102, m_so, 1'b1);
        #2;
        async_reset_now(103);
        @(negedge clk);
        check_model(104);
        resetn = 1'b1;
        step(1'b0, '0);
        check_model(105);
        step(1'b1, 8'h01);
        check_model(106);
        for (int i = 0; i < N + int'(PEN); i++) begin
            step(1'b0, '0);
            check_model(107 + i);
        end

        // Random traffic with occasional asynchronous resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 79) == 0) begin
                #2;
                async_reset_now(1000 + i);
                @(negedge clk);
                resetn = 1'b1;
            end
            lv = ($urandom_range(0, 3) != 0);
            d  = N'($urandom);
            step(lv, d);
            check_model(1000 + i);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
